// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, with a start/done handshake, registered carry-out and signed overflow.
module serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start; operands captured when start is seen
  // ADD   | one digit added per cycle, N cycles in total
  // DONE  | results valid, done pulses for this single cycle

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    count;

  logic [DIGIT:0]   dsum;
  logic [DIGIT-1:0] d;
  logic             c;
  logic [WIDTH-1:0] sum_next;
  logic             last;
  logic             ovf_next;

  assign dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign d    = dsum[DIGIT-1:0];
  assign c    = dsum[DIGIT];

  // New digit enters at the top; after N steps the first digit sits at bit 0.
  assign sum_next = (sum_sh >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));
  assign last     = (count == CW'(N - 1));
  assign ovf_next = (a_sh[DIGIT-1] == b_sh[DIGIT-1]) && (d[DIGIT-1] != a_sh[DIGIT-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      S      <= '0;
      Cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= Cin;
            count  <= '0;
            sum_sh <= '0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          sum_sh <= sum_next;
          carry  <= c;
          count  <= count + 1'b1;
          if (last) begin
            S     <= sum_next;
            Cout  <= c;
            ovf   <= ovf_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: one 8-bit/2-bit instance plus three 4-bit
// instances (DIGIT 1, 2, 4) swept over every operand combination.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       st1 = 1'b0, st2 = 1'b0, st4 = 1'b0;

  wire [7:0] s8;
  wire       c8, v8, busy8, done8;
  wire [3:0] s1, s2, s4;
  wire       c1, v1, busy1, done1;
  wire       c2, v2, busy2, done2;
  wire       c4, v4, busy4, done4;

  int total = 0;
  int bad = 0;
  int sel_cur = 0;

  logic [7:0] s_m;
  logic       c_m, v_m, busy_m, done_m;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .S(s8), .Cout(c8), .ovf(v8), .busy(busy8), .done(done8));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u4d1 (
    .clk(clk), .reset(reset), .start(st1), .A(a4), .B(b4), .Cin(cin4),
    .S(s1), .Cout(c1), .ovf(v1), .busy(busy1), .done(done1));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u4d2 (
    .clk(clk), .reset(reset), .start(st2), .A(a4), .B(b4), .Cin(cin4),
    .S(s2), .Cout(c2), .ovf(v2), .busy(busy2), .done(done2));
  serial_adder #(.WIDTH(4), .DIGIT(4)) u4d4 (
    .clk(clk), .reset(reset), .start(st4), .A(a4), .B(b4), .Cin(cin4),
    .S(s4), .Cout(c4), .ovf(v4), .busy(busy4), .done(done4));

  always_comb begin
    s_m = s8; c_m = c8; v_m = v8; busy_m = busy8; done_m = done8;
    case (sel_cur)
      1: begin s_m = {4'b0, s1}; c_m = c1; v_m = v1; busy_m = busy1; done_m = done1; end
      2: begin s_m = {4'b0, s2}; c_m = c2; v_m = v2; busy_m = busy2; done_m = done2; end
      3: begin s_m = {4'b0, s4}; c_m = c4; v_m = v4; busy_m = busy4; done_m = done4; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: start8 = v;
      1: st1 = v;
      2: st2 = v;
      default: st4 = v;
    endcase
  endtask

  // Called at posedge+1 with the selected instance in IDLE; returns the same way.
  task automatic op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic [7:0] exp_s, input logic exp_c, input logic exp_v,
                    input int nst, input string tag);
    int  n;
    int  nb;
    bit  seen;
    sel_cur = sel;
    if (sel == 0) begin a8 = a; b8 = b; cin8 = cin; end
    else begin a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; end
    set_start(sel, 1'b1);
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) set_start(sel, 1'b0);
      if (busy_m) nb++;
      if (done_m) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n), 32'(nst + 1));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(nst));
    chk({tag, "_sum"}, 32'(s_m), 32'(exp_s));
    chk({tag, "_cout"}, 32'(c_m), 32'(exp_c));
    chk({tag, "_ovf"}, 32'(v_m), 32'(exp_v));
    @(posedge clk); #1;
    chk({tag, "_done_width"}, 32'({busy_m, done_m}), 32'd0);
  endtask

  initial begin
    int sum;
    int nd;
    int nbz;
    logic ev;

    // Reset asserted from time zero: every output must read zero.
    #12;
    chk("rst_init_w8", 32'({s8, c8, v8, busy8, done8}), 32'd0);
    chk("rst_init_w4", 32'({s1, c1, v1, busy1, done1, s2, c2, v2, busy2, done2}), 32'd0);
    chk("rst_init_w4d4", 32'({s4, c4, v4, busy4, done4}), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    op(0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 4, "basic");
    op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 4, "wrap");
    op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4, "posovf");
    op(0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 4, "negovf");

    // Handshake: operands change and start stays high while busy.
    sel_cur = 0;
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin a8 = 8'hAA; b8 = 8'h55; end
      if (n == 4) chk("hs_prev_hold", 32'(s_m), 32'h01);
      if (n == 5) begin
        chk("hs_done1", 32'({busy_m, done_m}), 32'b01);
        chk("hs_sum1", 32'(s_m), 32'h4B);
      end
      if (n == 6) chk("hs_done1_width", 32'(done_m), 32'd0);
      if (n == 7) begin
        chk("hs_reaccept", 32'(busy_m), 32'd1);
        start8 = 1'b0;
      end
      if (n == 10) chk("hs_sum1_hold", 32'(s_m), 32'h4B);
      if (n == 11) begin
        chk("hs_done2", 32'({busy_m, done_m}), 32'b01);
        chk("hs_sum2", 32'({c_m, v_m, s_m}), 32'h0FF);
      end
    end

    // Reset during the second ADD cycle, asserted mid-cycle.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_async", 32'({s_m, c_m, v_m, busy_m, done_m}), 32'd0);
    nd = 0; nbz = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (n == 1) reset = 1'b0;
      if (done_m) nd++;
      if (busy_m) nbz++;
    end
    chk("rst_no_done", 32'(nd), 32'd0);
    chk("rst_stay_idle", 32'(nbz), 32'd0);
    chk("rst_sum_zero", 32'(s_m), 32'd0);
    op(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 4, "after_rst");

    // Every 4-bit operand pair and carry-in for each digit size.
    for (int sel = 1; sel <= 3; sel++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          for (int c = 0; c < 2; c++) begin
            sum = a + b + c;
            ev  = (a[3] == b[3]) && (sum[3] != a[3]);
            op(sel, 8'(a), 8'(b), c[0], {4'b0, sum[3:0]}, sum[4], ev,
               (sel == 1) ? 4 : (sel == 2) ? 2 : 1,
               $sformatf("ex_sel%0d_a%0d_b%0d_c%0d", sel, a, b, c));
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder. Adds two WIDTH-bit operands plus carry-in over WIDTH/DIGIT cycles, processing DIGIT bits per cycle with a registered carry. It uses a start/done handshake and reports carry-out and signed overflow. It is the sequential, width-generic successor to the combinational half/full adder cells, for datapaths that trade latency for carry-chain length.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  operand A; captured on accepted start.
- B  in  WIDTH  operand B; captured on accepted start.
- Cin  in  1  carry-in; captured on accepted start.
- S  out  WIDTH  registered sum (A+B+Cin) mod 2^WIDTH.
- Cout  out  1  registered unsigned carry-out.
- ovf  out  1  registered two's-complement overflow.
- busy  out  1  high while a sum is in progress (state ADD).
- done  out  1  one-cycle pulse; S/Cout/ovf are valid from this cycle onward.

## Operation
- N = WIDTH/DIGIT digit steps. Step counter width is clog2(N)+1.
- States: IDLE, ADD, DONE.
- IDLE, start=1: load A_sh←A, B_sh←B, carry←Cin, count←0, go to ADD. With start=0, stay in IDLE.
- ADD, each cycle:
  - {c, d} = A_sh[DIGIT-1:0] + B_sh[DIGIT-1:0] + carry (DIGIT+1 bits).
  - Shift d into the top of the partial-sum register (right shift by DIGIT).
  - A_sh, B_sh ← right shift by DIGIT; carry ← c; count++.
  - On step count = N-1:
    - Write the final sum to S and the final c to Cout.
    - ovf ← (a_msb == b_msb) && (sum_msb != a_msb), where a_msb/b_msb are the MSBs of the current digits.
    - Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. start is ignored in DONE.
- start in ADD or DONE is ignored; A/B/Cin changes have no effect after capture.
- S, Cout and ovf change only on the ADD→DONE edge. They hold until the next completed operation or reset and are never partial.
- reset (any state, any time): state←IDLE; S, Cout, ovf, busy, done, counter and shift registers ← 0. An in-flight operation is discarded with no done pulse.
- DIGIT=WIDTH is legal: N=1 gives a single ADD cycle.

## Timing
- start accepted at edge k (IDLE).
- busy=1 after edges k .. k+N-1, i.e. N cycles.
- Results are written at edge k+N. done=1 in the cycle after edge k+N.
- Back at IDLE after edge k+N+1.
- Latency from accepted start to done is N+1 edges. Minimum start-to-start spacing is N+2 cycles. start may be held high continuously; it is re-accepted on the first IDLE cycle.
- busy and done are never high together. done is exactly one cycle wide.
- Reset values: S=0, Cout=0, ovf=0, busy=0, done=0. Outputs go to 0 asynchronously on reset assertion, not at the next edge.

## Test plan
- Reset: assert reset mid-cycle with random prior state. Required: all outputs read 0 before the next clk edge, and the block stays in IDLE with start=0.
- WIDTH=8, DIGIT=2, A=8'h3C, B=8'h0F, Cin=0, start for 1 cycle. Required: busy for 4 cycles, then done pulse; S=8'h4B, Cout=0, ovf=0.
- Boundary sums, WIDTH=8, DIGIT=2. Required:
  - A=8'hFF, B=8'h01, Cin=0 → S=8'h00, Cout=1, ovf=0.
  - A=8'h7F, B=8'h01 → S=8'h80, Cout=0, ovf=1.
  - A=8'h80, B=8'h80, Cin=1 → S=8'h01, Cout=1, ovf=1.
- Handshake: during busy, drive start=1 with A=8'hAA, B=8'h55. Required: the result reflects the captured operands only. With start held high, the next operation starts on the first IDLE cycle after done, and the previous S is held until its done.
- Reset mid-operation: assert reset on the 2nd ADD cycle. Required: no done pulse and S=0. A fresh start afterwards yields the correct sum with normal latency.
- Exhaustive: run WIDTH=4 with DIGIT=1, 2 and 4, all A, B, Cin (512 cases each). Required: {Cout,S} == A+B+Cin, ovf matches the signed reference, and done arrives exactly N+1 edges after start.
